// File: rtl/sha512_state_unload.sv
// sha512_state_unload: captures the 8x64-bit SHA-512 state and drains it as OUT_WIDTH-bit chunks over valid/rd_en.
// Define SHA512_UNLOAD_BSWAP_EN to byte-reverse each output chunk for little-endian hosts.
module sha512_state_unload #(
  parameter int N = 64,
  parameter int NWORDS = 8,
  parameter int OUT_WIDTH = 32
) (
  input  logic                   CLK,
  input  logic                   rst_n,
  input  logic [NWORDS*N-1:0]    din,
  input  logic                   load,
  output logic                   ready,
  output logic [OUT_WIDTH-1:0]   dout,
  output logic                   dout_valid,
  output logic                   dout_last,
  input  logic                   rd_en
);
  localparam int W = NWORDS * N;
  localparam int CHUNKS = W / OUT_WIDTH;
  localparam int CW = CHUNKS > 1 ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [W-1:0] shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] chunk;
  logic load_ok, acc;
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q <= cnt_d;
    end
  end
  // a load on the last-chunk accept takes priority so the new state follows without a bubble
  always_comb begin
    load_ok = load & ready;
    acc = dout_valid & rd_en;
    state_d = load_ok ? SEND : (acc & dout_last) ? IDLE : state_q;
    shift_d = load_ok ? din : acc ? shift_q << OUT_WIDTH : shift_q;
    cnt_d = load_ok ? '0 : acc ? cnt_q + 1'b1 : cnt_q;
  end
  always_comb begin
    dout_valid = state_q == SEND;
    dout_last = dout_valid & (cnt_q == LAST);
    ready = (state_q == IDLE) | (dout_last & rd_en);
    chunk = shift_q[W-1 -: OUT_WIDTH];
  end
`ifdef SHA512_UNLOAD_BSWAP_EN
  for (genvar b = 0; b < OUT_WIDTH / 8; b++) begin : g_bswap
    assign dout[b*8 +: 8] = chunk[OUT_WIDTH-1-b*8 -: 8];
  end
`else
  assign dout = chunk;
`endif
endmodule

// File: tb/tb_sha512_state_unload.sv
// tb_sha512_state_unload: directed table-driven and sequence checks of the SHA-512 state unloader.
module tb_sha512_state_unload;
  logic clk = 0, rst_n = 0, load = 0, rd_en = 0;
  logic [511:0] din = '0;
  logic ready, dout_valid, dout_last;
  logic [31:0] dout;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic load;
    logic rd_en;
    logic [31:0] dout;
    logic valid;
    logic last;
    logic ready;
  } vec_t;
  vec_t tbl[18];
  logic [511:0] din_a, din_f, din_b;

  sha512_state_unload dut (
    .CLK(clk), .rst_n(rst_n), .din(din), .load(load), .ready(ready),
    .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last), .rd_en(rd_en)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ch_a(int i);
    return 32'h01010101 * 32'(i / 2 + 1);
  endfunction

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic outs(string tag, logic [31:0] d, logic v, logic l, logic r);
    check({tag, ".dout"}, dout, d);
    check({tag, ".valid"}, 32'(dout_valid), 32'(v));
    check({tag, ".last"}, 32'(dout_last), 32'(l));
    check({tag, ".ready"}, 32'(ready), 32'(r));
  endtask

  task automatic cyc(logic r, logic l, logic e, logic [511:0] d);
    @(negedge clk);
    rst_n = r; load = l; rd_en = e; din = d;
    #1;
  endtask

  initial begin
    int idx, cnt;
    for (int k = 0; k < 8; k++) begin
      din_a[(8-k)*64-1 -: 64] = 64'h0101010101010101 * 64'(k + 1);
      din_f[(8-k)*64-1 -: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
    end
    din_b = '0;
    din_b[511 -: 64] = 64'h0011223344556677;
    tbl[0] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1};
    for (int i = 1; i <= 16; i++) tbl[i] = '{1'b0, 1'b1, ch_a(i - 1), 1'b1, i == 16, i == 16};
    tbl[17] = '{1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1};

    // reset then idle, rd_en pulses ignored
    cyc(0, 0, 0, '0);
    cyc(0, 0, 1, '0);
    cyc(1, 0, 0, '0);
    outs("reset", 32'h0, 0, 0, 1);
    cyc(1, 0, 1, '0);
    outs("idle_rd", 32'h0, 0, 0, 1);
    cyc(1, 0, 1, '0);
    outs("idle_rd2", 32'h0, 0, 0, 1);

    // single drain from table
    for (int i = 0; i < 18; i++) begin
      cyc(1, tbl[i].load, tbl[i].rd_en, din_a);
      outs($sformatf("drain[%0d]", i), tbl[i].dout, tbl[i].valid, tbl[i].last, tbl[i].ready);
    end

    // backpressure 1,0,0,1,... with ignored mid-drain loads of all-ones
    cyc(1, 1, 0, din_a);
    idx = 0; cnt = 0;
    while (idx < 16 && cnt < 100) begin
      logic e;
      e = (cnt % 3) == 0;
      cyc(1, idx < 15, e, din_f);
      outs($sformatf("bp[%0d]", idx), ch_a(idx), 1, idx == 15, idx == 15 && e);
      if (e) idx++;
      cnt++;
    end
    check("bp.bound", 32'(idx), 32'd16);
    cyc(1, 0, 0, '0);
    outs("bp.end", 32'h0, 0, 0, 1);

    // back-to-back: second load on last-chunk accept, no bubble
    cyc(1, 1, 0, din_a);
    for (int i = 0; i < 32; i++) begin
      cyc(1, i == 15, 1, i == 15 ? din_f : din_a);
      outs($sformatf("b2b[%0d]", i), i < 16 ? ch_a(i) : 32'hFFFFFFFF, 1, i == 15 || i == 31, i == 15 || i == 31);
    end
    cyc(1, 0, 1, '0);
    outs("b2b.end", 32'h0, 0, 0, 1);

    // reset mid-drain after five chunks, then restart
    cyc(1, 1, 0, din_a);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 1, '0);
      outs($sformatf("rmd[%0d]", i), ch_a(i), 1, 0, 0);
    end
    cyc(0, 0, 1, '0);
    cyc(1, 0, 1, '0);
    outs("rmd.reset", 32'h0, 0, 0, 1);
    cyc(1, 1, 0, din_a);
    cyc(1, 0, 0, '0);
    outs("rmd.restart", ch_a(0), 1, 0, 0);
    cyc(0, 0, 0, '0);

    // chunk order within a word, with optional byte swap
    cyc(1, 1, 0, din_b);
    cyc(1, 0, 1, '0);
`ifdef SHA512_UNLOAD_BSWAP_EN
    outs("bs[0]", 32'h33221100, 1, 0, 0);
    cyc(1, 0, 0, '0);
    outs("bs[1]", 32'h77665544, 1, 0, 0);
`else
    outs("bs[0]", 32'h00112233, 1, 0, 0);
    cyc(1, 0, 0, '0);
    outs("bs[1]", 32'h44556677, 1, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
